// File: rtl/ofmap_requant_packer.sv
// Requantizes one PE-array ofmap vector (LANES x ACC_W) to int8 lanes, one lane
// per cycle, and presents the packed word on a ready/valid output.
module ofmap_requant_packer #(
  parameter int LANES = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic signed [ACC_W-1:0]       ofmap [0:LANES-1],
  input  logic        [4:0]             cfg_shift,
  input  logic                          cfg_relu,
  output logic        [OUT_W*LANES-1:0] o_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic                          o_busy,
  output logic                          o_overflow
);

  // state | meaning
  // IDLE  | no conversion running; buffer may hold a vector waiting for the output slot
  // CONV  | converting buffered lane lane_q; stalls on the last lane while o_data is unaccepted
  typedef enum logic {IDLE, CONV} state_t;

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = OUT_W * (LANES - 1);
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  state_t                      state_q;
  logic [LW-1:0]               lane_q;
  logic signed [ACC_W-1:0]     buf_q [0:LANES-1];
  logic [4:0]                  shift_q;
  logic                        relu_q;
  logic                        buf_full_q;
  logic [PW-1:0]               pack_q;
  logic [OUT_W*LANES-1:0]      data_q;
  logic                        valid_q;
  logic                        ovf_q;

  logic signed [ACC_W:0]       ext_d, rnd_d, shf_d;
  logic [OUT_W-1:0]            byte_d;
  logic                        finish, capture, start;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    ext_d = {buf_q[lane_q][ACC_W-1], buf_q[lane_q]};
    rnd_d = ext_d + ((ACC_W+1)'(1) << (shift_q - 5'd1));
    shf_d = (shift_q == 5'd0) ? ext_d : (rnd_d >>> shift_q);
    if (relu_q && shf_d[ACC_W]) shf_d = '0;
    byte_d = shf_d[OUT_W-1:0];
    if (shf_d > SAT_MAX)      byte_d = SAT_MAX[OUT_W-1:0];
    else if (shf_d < SAT_MIN) byte_d = SAT_MIN[OUT_W-1:0];
  end

  always_comb begin
    finish  = (state_q == CONV) && (lane_q == LAST) && (!valid_q || o_ready);
    capture = i_valid && (!buf_full_q || finish);
    start   = ((state_q == IDLE) ? (buf_full_q || capture) : (finish && capture))
              && (!valid_q || o_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      for (int k = 0; k < LANES; k++) buf_q[k] <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      buf_full_q <= 1'b0;
      pack_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (capture) begin
        buf_q   <= ofmap;
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu;
      end
      if (capture)     buf_full_q <= 1'b1;
      else if (finish) buf_full_q <= 1'b0;
      if (i_valid && !capture) ovf_q <= 1'b1;
      if (finish) begin
        data_q  <= {byte_d, pack_q};
        valid_q <= 1'b1;
      end else if (o_ready) begin
        valid_q <= 1'b0;
      end
      if (start) begin
        state_q <= CONV;
        lane_q  <= '0;
      end else if (finish) begin
        state_q <= IDLE;
      end else if (state_q == CONV && lane_q != LAST) begin
        pack_q[lane_q*OUT_W +: OUT_W] <= byte_d;
        lane_q <= lane_q + LW'(1);
      end
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_busy     = buf_full_q;
  assign o_overflow = ovf_q;

endmodule
